// File: rtl/md_ctrl.sv
// md_ctrl: sequencer for the shared multi-cycle mult/div unit.
// Issues a DX-stage mul/div, freezes PC/FD/DX while the unit works, then
// hands result rd/exception to XM for one cycle. A timeout forces an
// exception when the unit never answers. A saturating counter tracks stalls.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_dx_is_mult/div      DX instruction is mul/div
//   i_dx_rd[4:0]          DX destination register
//   i_flush               squash DX this cycle, blocks issue
//   i_md_rdy, i_md_exc    unit completion pulse and exception flag
//   o_ctrl_mult/div       start pulses to the unit
//   o_stall               hold PC/FD/DX, bubble into XM
//   o_md_done             op completes, load XM with is_md=1
//   o_md_rd[4:0], o_md_ex rd and exception for XM (valid with o_md_done)
//   o_md_busy             sequencer not idle
//   o_stall_cycles[31:0]  saturating count of stall cycles
module md_ctrl #(
  parameter int unsigned TIMEOUT = 34,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned EX_RD   = 30
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dx_is_mult,
  input  logic        i_dx_is_div,
  input  logic [4:0]  i_dx_rd,
  input  logic        i_flush,
  input  logic        i_md_rdy,
  input  logic        i_md_exc,
  output logic        o_ctrl_mult,
  output logic        o_ctrl_div,
  output logic        o_stall,
  output logic        o_md_done,
  output logic [4:0]  o_md_rd,
  output logic        o_md_ex,
  output logic        o_md_busy,
  output logic [31:0] o_stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [4:0]         r_rd_q;
  logic               r_ex_q;
  logic [31:0]        r_stall_cycles;
  logic               w_issue;
  logic               w_timeout;

  assign w_issue   = (r_state == S_IDLE) && !i_flush && (i_dx_is_mult || i_dx_is_div);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY:  if (i_md_rdy || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs; all forced low while reset is asserted
  always_comb begin
    o_ctrl_mult    = 1'b0;
    o_ctrl_div     = 1'b0;
    o_stall        = 1'b0;
    o_md_done      = 1'b0;
    o_md_rd        = 5'd0;
    o_md_ex        = 1'b0;
    o_md_busy      = 1'b0;
    o_stall_cycles = 32'd0;
    if (!i_reset) begin
      o_stall_cycles = r_stall_cycles;
      o_md_busy      = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          // multiply wins when both decode bits are set
          o_ctrl_mult = w_issue && i_dx_is_mult;
          o_ctrl_div  = w_issue && !i_dx_is_mult;
          o_stall     = w_issue;
        end
        S_BUSY: o_stall = 1'b1;
        S_DONE: begin
          o_md_done = 1'b1;
          o_md_rd   = r_ex_q ? 5'(EX_RD) : r_rd_q;
          o_md_ex   = r_ex_q;
        end
        default: ;
      endcase
    end
  end

  // Busy counter, captured rd/exception and stall counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt          <= '0;
      r_rd_q         <= '0;
      r_ex_q         <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_issue) begin
        r_rd_q <= i_dx_rd;
        r_cnt  <= '0;
      end
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (i_md_rdy)       r_ex_q <= i_md_exc;
        else if (w_timeout) r_ex_q <= 1'b1;
      end
      if (o_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based transaction model.
module tb_md_ctrl;
  localparam int unsigned TIMEOUT = 34;
  localparam int unsigned EX_RD   = 30;

  logic        clk = 1'b0;
  logic        reset, dx_is_mult, dx_is_div, flush, md_rdy, md_exc;
  logic [4:0]  dx_rd;
  logic        ctrl_mult, ctrl_div, stall, md_done, md_ex, md_busy;
  logic [4:0]  md_rd;
  logic [31:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int n_mult_pulses = 0;
  int n_div_pulses  = 0;

  always #5 clk = ~clk;

  md_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6), .EX_RD(EX_RD)) dut (
    .i_clk(clk), .i_reset(reset), .i_dx_is_mult(dx_is_mult), .i_dx_is_div(dx_is_div),
    .i_dx_rd(dx_rd), .i_flush(flush), .i_md_rdy(md_rdy), .i_md_exc(md_exc),
    .o_ctrl_mult(ctrl_mult), .o_ctrl_div(ctrl_div), .o_stall(stall), .o_md_done(md_done),
    .o_md_rd(md_rd), .o_md_ex(md_ex), .o_md_busy(md_busy), .o_stall_cycles(stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: an op is either absent, in flight (with elapsed busy
  // cycles), or completing this cycle with a known rd/exception.
  bit          m_inflight = 0;
  bit          m_completing = 0;
  int          m_elapsed = 0;
  logic [4:0]  m_rd = 0;
  bit          m_ex = 0;
  longint      m_stalls = 0;

  always @(negedge clk) begin
    bit e_mult, e_div, e_stall, e_done, e_ex, e_busy, want;
    logic [4:0] e_rd;
    e_mult = 0; e_div = 0; e_stall = 0; e_done = 0; e_ex = 0; e_busy = 0; e_rd = 0;
    want = !flush && (dx_is_mult || dx_is_div);
    if (!reset) begin
      if (m_completing) begin
        e_done = 1; e_busy = 1; e_ex = m_ex;
        e_rd = m_ex ? 5'(EX_RD) : m_rd;
      end else if (m_inflight) begin
        e_stall = 1; e_busy = 1;
      end else if (want) begin
        e_stall = 1; e_mult = dx_is_mult; e_div = !dx_is_mult;
      end
    end
    chk("ctrl_mult", 32'(ctrl_mult), 32'(e_mult));
    chk("ctrl_div",  32'(ctrl_div),  32'(e_div));
    chk("stall",     32'(stall),     32'(e_stall));
    chk("md_done",   32'(md_done),   32'(e_done));
    chk("md_rd",     32'(md_rd),     32'(e_rd));
    chk("md_ex",     32'(md_ex),     32'(e_ex));
    chk("md_busy",   32'(md_busy),   32'(e_busy));
    chk("stall_cycles", stall_cycles, reset ? 32'd0 : 32'(m_stalls));
    if (ctrl_mult) n_mult_pulses++;
    if (ctrl_div)  n_div_pulses++;
    // advance the model across the coming edge
    if (reset) begin
      m_inflight = 0; m_completing = 0; m_elapsed = 0; m_rd = 0; m_ex = 0; m_stalls = 0;
    end else begin
      if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_completing) begin
        m_completing = 0;
      end else if (m_inflight) begin
        m_elapsed++;
        if (md_rdy) begin
          m_inflight = 0; m_completing = 1; m_ex = md_exc;
        end else if (m_elapsed == TIMEOUT) begin
          m_inflight = 0; m_completing = 1; m_ex = 1;
        end
      end else if (want) begin
        m_inflight = 1; m_elapsed = 0; m_rd = dx_rd;
      end
    end
  end

  // Advance one cycle and apply the inputs for it
  task automatic go(input logic rst, input logic m, input logic d, input logic [4:0] rd,
                    input logic fl, input logic rdy, input logic exc);
    @(posedge clk); #1;
    reset = rst; dx_is_mult = m; dx_is_div = d; dx_rd = rd;
    flush = fl; md_rdy = rdy; md_exc = exc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    go(1, 0, 0, 5'd0, 0, 1, 1);
    go(1, 0, 0, 5'd0, 0, 0, 0);
  endtask

  int p0;

  initial begin
    reset = 1; dx_is_mult = 0; dx_is_div = 0; dx_rd = 0; flush = 0; md_rdy = 0; md_exc = 0;
    do_reset();
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);

    // 1: mul rd=5, rdy 3 cycles after issue
    idle(1);
    p0 = n_mult_pulses;
    go(0, 1, 0, 5'd5, 0, 0, 0);
    chk("t1_issue_mult", 32'(ctrl_mult), 32'd1);
    idle(2);
    go(0, 0, 0, 5'd0, 0, 1, 0);
    idle(1);
    chk("t1_done", 32'(md_done), 32'd1);
    chk("t1_rd", 32'(md_rd), 32'd5);
    chk("t1_ex", 32'(md_ex), 32'd0);
    chk("t1_stall_cycles", stall_cycles, 32'd4);
    idle(1);
    chk("t1_pulses", 32'(n_mult_pulses - p0), 32'd1);

    // 2: div rd=7 with exception
    do_reset();
    p0 = n_div_pulses;
    go(0, 0, 1, 5'd7, 0, 0, 0);
    go(0, 0, 0, 5'd0, 0, 1, 1);
    idle(1);
    chk("t2_done", 32'(md_done), 32'd1);
    chk("t2_rd", 32'(md_rd), 32'd30);
    chk("t2_ex", 32'(md_ex), 32'd1);
    idle(1);
    chk("t2_pulses", 32'(n_div_pulses - p0), 32'd1);

    // 3: unit never responds
    do_reset();
    go(0, 1, 0, 5'd9, 0, 0, 0);
    idle(34);
    chk("t3_not_yet", 32'(md_done), 32'd0);
    idle(1);
    chk("t3_done", 32'(md_done), 32'd1);
    chk("t3_rd", 32'(md_rd), 32'd30);
    chk("t3_ex", 32'(md_ex), 32'd1);
    chk("t3_stall_cycles", stall_cycles, 32'd35);

    // 4: flushed mul does not issue, next cycle it does
    do_reset();
    go(0, 1, 0, 5'd2, 1, 0, 0);
    chk("t4_flush_ctrl", 32'(ctrl_mult), 32'd0);
    chk("t4_flush_stall", 32'(stall), 32'd0);
    go(0, 1, 0, 5'd2, 0, 0, 0);
    chk("t4_busy_after_flush", 32'(md_busy), 32'd0);
    chk("t4_issue", 32'(ctrl_mult), 32'd1);
    go(0, 0, 0, 5'd0, 0, 1, 0);
    idle(2);

    // 5: reset two cycles into BUSY, late rdy ignored
    do_reset();
    go(0, 1, 0, 5'd6, 0, 0, 0);
    idle(1);
    go(1, 0, 0, 5'd0, 0, 0, 0);
    go(0, 0, 0, 5'd0, 0, 1, 0);
    chk("t5_no_done", 32'(md_done), 32'd0);
    chk("t5_busy", 32'(md_busy), 32'd0);
    chk("t5_stall_cycles", stall_cycles, 32'd0);
    idle(1);
    chk("t5_still_no_done", 32'(md_done), 32'd0);

    // 6: back-to-back muls, DX held during DONE must not re-issue
    do_reset();
    p0 = n_mult_pulses;
    go(0, 1, 0, 5'd3, 0, 0, 0);
    go(0, 1, 0, 5'd3, 0, 1, 0);
    go(0, 1, 0, 5'd3, 0, 0, 0);
    chk("t6_done1", 32'(md_done), 32'd1);
    chk("t6_rd1", 32'(md_rd), 32'd3);
    chk("t6_no_reissue", 32'(ctrl_mult), 32'd0);
    go(0, 1, 0, 5'd4, 0, 0, 0);
    go(0, 0, 0, 5'd0, 0, 1, 0);
    idle(1);
    chk("t6_done2", 32'(md_done), 32'd1);
    chk("t6_rd2", 32'(md_rd), 32'd4);
    idle(1);
    chk("t6_pulses", 32'(n_mult_pulses - p0), 32'd2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      go(($urandom % 250) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
         5'($urandom), ($urandom % 5) == 0, ($urandom % 9) == 0, ($urandom % 2) == 0);
    end
    // Long quiet stretch so timeouts also occur under random DX traffic
    go(0, 1, 0, 5'd11, 0, 0, 0);
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
